// File: rtl/ones_pattern_generator_pkg.sv
// ones_gen_pkg: shared types and constants for the ones-pattern generator.
//   state_t       - FSM state encoding (S_idle=0, S_fill=1, S_done=2); fixed
//                   values so a bench can decode ps numerically.
//   DEFAULT_WIDTH - default pattern width.
package ones_gen_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_idle = 2'd0,
        S_fill = 2'd1,
        S_done = 2'd2
    } state_t;

endpackage

// File: rtl/ones_pattern_generator_if.sv
// ones_pattern_generator_if: start/done handshake plus result bus.
//   s, count_in          - requester -> generator (start, requested ones)
//   pattern              - thermometer word, valid while done=1
//   ser_bit, ser_valid   - serial copy of each bit as it is shifted in
//   busy, done, sat      - status; sat flags a clipped count
// Modports: master = requester side, slave = generator side.
interface ones_pattern_generator_if #(
    parameter int WIDTH = ones_gen_pkg::DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             s;
    logic [CW-1:0]    count_in;
    logic [WIDTH-1:0] pattern;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;
    logic             done;
    logic             sat;

    modport master (
        output s, count_in,
        input  pattern, ser_bit, ser_valid, busy, done, sat
    );

    modport slave (
        input  s, count_in,
        output pattern, ser_bit, ser_valid, busy, done, sat
    );
endinterface

// File: rtl/ones_pattern_generator_control.sv
// ones_pattern_control: three-state FSM sequencing one pattern build.
//   clk, reset   - clock, synchronous active-low reset
//   s            - start request (only honoured in S_idle)
//   last_bit     - datapath is on its final shift
//   load         - capture count / clear datapath this edge
//   shift        - shift one bit this edge (S_fill)
//   busy, done   - Moore status decoded from ps
//   ps           - registered state
module ones_pattern_control
    import ones_gen_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   s,
    input  logic   last_bit,
    output logic   load,
    output logic   shift,
    output logic   busy,
    output logic   done,
    output state_t ps
);

    state_t w_ns;

    always_ff @(posedge clk) begin
        if (!reset) ps <= S_idle;
        else        ps <= w_ns;
    end

    always_comb begin
        w_ns  = ps;
        load  = 1'b0;
        shift = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (ps)
            S_idle: begin
                if (s) begin
                    load = 1'b1;
                    w_ns = S_fill;
                end
            end
            S_fill: begin
                shift = 1'b1;
                busy  = 1'b1;
                if (last_bit) w_ns = S_done;
            end
            S_done: begin
                done = 1'b1;
                // A held start must not retrigger; wait for s to drop.
                if (!s) w_ns = S_idle;
            end
            default: w_ns = S_idle;
        endcase
    end

endmodule

// File: rtl/ones_pattern_generator.sv
// ones_pattern_generator: serially builds a WIDTH-bit thermometer word with
// min(count_in, WIDTH) ones in the LSBs, one bit per clock, and streams each
// bit on ser_bit.
//   clk, reset - clock, synchronous active-low reset
//   bus        - slave side of ones_pattern_generator_if (s, count_in in;
//                pattern, ser_bit, ser_valid, busy, done, sat out)
module ones_pattern_generator
    import ones_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    ones_pattern_generator_if.slave   bus
);

    localparam logic [CW-1:0] W_CNT  = CW'(WIDTH);
    localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_pattern;
    logic [CW-1:0]    r_ones_left;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_sat;

    logic   w_load;
    logic   w_shift;
    logic   w_last_bit;
    logic   w_busy;
    logic   w_done;
    logic   w_ser_bit;
    logic   w_over;
    state_t w_ps;

    assign w_last_bit = (r_bit_cnt == W_LAST);
    assign w_over     = (bus.count_in > W_CNT);
    // Registered-only decode: no path from s/count_in to ser_bit.
    assign w_ser_bit  = w_shift && (r_ones_left != '0);

    ones_pattern_control u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .s        (bus.s),
        .last_bit (w_last_bit),
        .load     (w_load),
        .shift    (w_shift),
        .busy     (w_busy),
        .done     (w_done),
        .ps       (w_ps)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pattern   <= '0;
            r_ones_left <= '0;
            r_bit_cnt   <= '0;
            r_sat       <= 1'b0;
        end else if (w_load) begin
            r_pattern   <= '0;
            r_ones_left <= w_over ? W_CNT : bus.count_in;
            r_bit_cnt   <= '0;
            r_sat       <= w_over;
        end else if (w_shift) begin
            // New bit enters at the MSB; after WIDTH shifts the first
            // generated bits sit in the LSBs.
            r_pattern <= {w_ser_bit, r_pattern[WIDTH-1:1]};
            if (r_ones_left != '0) r_ones_left <= r_ones_left - 1'b1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign bus.pattern   = r_pattern;
    assign bus.ser_bit   = w_ser_bit;
    assign bus.ser_valid = w_shift;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.sat       = r_sat;

endmodule

// File: tb/tb_ones_pattern_generator.sv
module tb_ones_pattern_generator;
    import ones_gen_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ones_pattern_generator_if #(.WIDTH(W), .CW(CW)) bus ();

    ones_pattern_generator #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: ones count clipped to W, thermometer word of that many ones.
    function automatic int clip(input int n);
        return (n > W) ? W : n;
    endfunction

    function automatic logic [31:0] ref_pattern(input int n);
        longint unsigned p;
        p = (64'd1 << clip(n)) - 64'd1;
        return 32'(p[W-1:0]);
    endfunction

    // One complete request. Called at a negedge with the DUT in S_idle.
    // noise: scribble on s/count_in during the fill; hold: keep s high in done.
    task automatic run(input int n, input bit noise, input bit hold, input string nm);
        logic [31:0] pat;
        bus.s        = 1'b1;
        bus.count_in = CW'(n);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk({nm, ":ser_valid"}, 32'(bus.ser_valid), 1);
            chk({nm, ":busy"},      32'(bus.busy), 1);
            chk({nm, ":done_early"}, 32'(bus.done), 0);
            chk({nm, ":ser_bit"},   32'(bus.ser_bit), (i < clip(n)) ? 1 : 0);
            if (i == W - 1) bus.s = hold;
            else            bus.s = noise ? 1'($urandom) : 1'b0;
            bus.count_in = noise ? CW'($urandom) : bus.count_in;
        end
        @(negedge clk);
        chk({nm, ":done"},      32'(bus.done), 1);
        chk({nm, ":pattern"},   32'(bus.pattern), ref_pattern(n));
        chk({nm, ":sat"},       32'(bus.sat), (n > W) ? 1 : 0);
        chk({nm, ":ser_valid_off"}, 32'(bus.ser_valid), 0);
        pat = 32'(bus.pattern);
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk({nm, ":hold_done"}, 32'(bus.done), 1);
                chk({nm, ":hold_pat"},  32'(bus.pattern), pat);
            end
        end
        bus.s = 1'b0;
        @(negedge clk);
        chk({nm, ":back_idle"}, 32'(dut.u_ctrl.ps), 32'(S_idle));
        chk({nm, ":done_clr"},  32'(bus.done), 0);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        bus.s        = 1'b1;
        bus.count_in = CW'(3);
        // Reset held 2 cycles with s asserted.
        repeat (2) @(negedge clk);
        chk("rst:ps",        32'(dut.u_ctrl.ps), 32'(S_idle));
        chk("rst:pattern",   32'(bus.pattern), 0);
        chk("rst:ser_bit",   32'(bus.ser_bit), 0);
        chk("rst:ser_valid", 32'(bus.ser_valid), 0);
        chk("rst:busy",      32'(bus.busy), 0);
        chk("rst:done",      32'(bus.done), 0);
        chk("rst:sat",       32'(bus.sat), 0);
        reset = 1'b1;
        bus.s = 1'b0;
        @(negedge clk);
        chk("post_rst:idle", 32'(dut.u_ctrl.ps), 32'(S_idle));
        chk("post_rst:busy", 32'(bus.busy), 0);

        run(3,  0, 0, "typ3");
        run(0,  0, 0, "zero");
        run(8,  0, 0, "full");
        run(12, 0, 1, "sat12_hold");
        run(1,  0, 0, "one_clr_sat");
        run(6,  1, 0, "noise6");

        // Reset in the middle of a fill.
        bus.s        = 1'b1;
        bus.count_in = CW'(5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.s = 1'b0;
        end
        chk("midrst:busy_before", 32'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst:ps",      32'(dut.u_ctrl.ps), 32'(S_idle));
        chk("midrst:pattern", 32'(bus.pattern), 0);
        chk("midrst:busy",    32'(bus.busy), 0);
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            chk("midrst:no_done", 32'(bus.done), 0);
        end

        // Randomized requests over the full count_in range.
        for (int r = 0; r < 20; r++) begin
            n = int'($urandom_range(0, (1 << CW) - 1));
            run(n, 1'($urandom), 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ones_pattern_generator.md
# ones_pattern_generator

Sequential inverse of the bit-counter unit. Given a count N, it serially builds a WIDTH-bit thermometer word with exactly N ones in the LSBs, one bit per clock. It also streams each generated bit on a serial output. It uses the same start/done handshake as the bit-counter control and sits beside it in the Blackjack datapath, for example to build hand/card masks from a tally.

## Interface
Parameters:
- WIDTH, default 8: pattern width; must be ≥ 2.
- CW, default $clog2(WIDTH+1): width of the count input and of the internal counters.

Ports:
- clk  in  1: sole clock; all state updates on the rising edge.
- reset  in  1: synchronous, active-low reset; sampled on the rising clk edge.
- s  in  1: start request; sampled only in S_idle.
- count_in  in  CW: requested number of ones; sampled in the same cycle s is accepted.
- pattern  out  WIDTH: generated thermometer word; valid while done=1.
- ser_bit  out  1: bit being shifted in this cycle.
- ser_valid  out  1: high exactly in S_fill cycles.
- busy  out  1: high in S_fill.
- done  out  1: high in S_done.
- sat  out  1: latched when the accepted count_in exceeds WIDTH; cleared on the next accepted start.

## Operation
- States are S_idle, S_fill and S_done.
- **S_idle:**
  - If s=1, go to S_fill.
  - At that same edge: ones_left ← min(count_in, WIDTH), sat ← (count_in > WIDTH), bit_cnt ← 0, pattern ← 0.
  - Otherwise hold all registers.
- **S_fill:**
  - ser_valid=1 and ser_bit=(ones_left≠0).
  - Each edge: pattern ← {ser_bit, pattern[WIDTH-1:1]} (right shift, new bit enters at MSB).
  - Each edge: if ones_left≠0, ones_left ← ones_left−1; bit_cnt ← bit_cnt+1.
  - When bit_cnt = WIDTH−1, the shift at that edge is the last, and the next state is S_done.
  - s is ignored during S_fill.
- **S_done:**
  - done=1 and pattern is held.
  - Stay while s=1; go to S_idle when s=0. This prevents a held start from retriggering.
- **Result:** after WIDTH shifts the first-generated bits occupy the LSBs, so pattern = (1<<N)−1. For N=WIDTH the pattern is all ones.
- **Saturation:** any count_in > WIDTH behaves as WIDTH, with sat=1.
- **Reset (reset=0 at an edge):**
  - ps ← S_idle.
  - pattern, ones_left, bit_cnt and sat ← 0.
  - Reset overrides every other transition, including reset in the middle of S_fill. The partial pattern is discarded.
- **Reset output values:** pattern=0, ser_bit=0, ser_valid=0, busy=0, done=0, sat=0.
- ser_bit, ser_valid, busy and done are Moore outputs decoded from the registered state and ones_left. They are glitch-free relative to clk and have no combinational path from any input.

## Timing
- Cycle 0: s=1 sampled in S_idle.
- Cycles 1..WIDTH: S_fill; ser_valid high for exactly WIDTH cycles.
- Cycle WIDTH+1: done=1 and pattern final.
- Start-to-done latency is fixed at WIDTH+1 cycles, independent of N, including N=0.
- ser_bit is 1 for the first min(N,WIDTH) S_fill cycles and 0 for the rest.
- Minimum restart: s low for one cycle in S_done returns to S_idle at the next edge. A new s is accepted one cycle later.
- A simultaneous s=1 and reset=0 resolves to reset.
- count_in is don't-care outside the accept cycle.

## Structure
- Package ones_gen_pkg holds:
  - the state enum typedef (S_idle, S_fill, S_done), encoded 0/1/2 so benches can decode ps numerically;
  - a helper constant for the default WIDTH.
- Top module ones_pattern_generator contains the datapath: pattern shift register, ones_left and bit_cnt down/up counters, and the saturation compare.
- One sub-module, ones_pattern_control, holds the FSM. It takes s, last_bit (bit_cnt==WIDTH−1) and reset, and drives load, shift, busy and done. The state register is named ps.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with s=1 → all outputs 0, ps=S_idle; after release, the first accept occurs only on a subsequent s.
- **Typical count:** WIDTH=8, count_in=3, s pulse → ser_bit stream 1,1,1,0,0,0,0,0 with ser_valid high 8 cycles; done at cycle 9; pattern=8'h07; sat=0.
- **Boundaries:**
  - count_in=0 → ser_bit all 0, pattern=8'h00, done still at cycle 9.
  - count_in=8 → pattern=8'hFF.
  - count_in=12 → pattern=8'hFF, sat=1.
- **Reset mid-run:** reset=0 at S_fill cycle 4 of count_in=5 → next cycle S_idle, pattern=0, no done pulse.
- **Handshake:**
  - s held high through completion → stays in S_done with pattern stable.
  - Drop s for 1 cycle, then s=1 with count_in=1 → second run yields 8'h01 and clears sat.
- **Ignored start:** changing count_in and s during S_fill → no effect on the in-flight result.
